uart_tx_frame: RTL and testbench

UART transmit framer: accepts a parallel data word with a one-cycle valid strobe and serialises it as start bit, data LSB first, optional parity bit and stop bit onto a single line. It is the transmit-side counterpart to the receiver's parity checker and deserialiser, sharing the same parity-type encoding. Each bit is held for a programmable number of clock cycles. Instantiated in the UART top level next to the RX path.

---
 rtl/uart_tx_frame.sv | 111 +++++++++++
 tb/tb_uart_tx_frame.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start bit, LSB-first data, optional parity, stop bit.
// Outputs are registered from the current state, one cycle behind acceptance.
module uart_tx_frame #(
    parameter int DATA_LENGTH = 8,
    parameter int PRESCALE_W  = 6
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [DATA_LENGTH-1:0] P_DATA,
    input  logic                   DATA_VALID,
    input  logic                   PAR_EN,
    input  logic                   PAR_TYP,
    input  logic [PRESCALE_W-1:0]  PRESCALE,
    output logic                   TX_OUT,
    output logic                   Busy
);
    localparam int IDX_W = (DATA_LENGTH > 1) ? $clog2(DATA_LENGTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_LENGTH - 1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
    localparam logic [PRESCALE_W-1:0] P_ONE = PRESCALE_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                 state;
    logic [PRESCALE_W-1:0]  timer;
    logic [PRESCALE_W-1:0]  presc_q;
    logic [IDX_W-1:0]       bit_idx;
    logic [DATA_LENGTH-1:0] data_q;
    logic                   par_en_q;
    logic                   par_typ_q;
    logic                   bit_done;
    logic                   par_bit;

    // A latched prescale of 0 behaves as 1: the timer never leaves 0.
    assign bit_done = (presc_q == '0) || (timer == presc_q - P_ONE);
    assign par_bit  = par_typ_q ? ~^data_q : ^data_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            timer     <= '0;
            bit_idx   <= '0;
            presc_q   <= '0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            TX_OUT    <= 1'b1;
            Busy      <= 1'b0;
        end else begin
            if (state != IDLE) begin
                timer <= bit_done ? '0 : timer + P_ONE;
            end
            unique case (state)
                IDLE: begin
                    TX_OUT <= 1'b1;
                    Busy   <= 1'b0;
                    timer  <= '0;
                    if (DATA_VALID) begin
                        data_q    <= P_DATA;
                        par_en_q  <= PAR_EN;
                        par_typ_q <= PAR_TYP;
                        presc_q   <= PRESCALE;
                        state     <= START;
                    end
                end
                START: begin
                    TX_OUT <= 1'b0;
                    Busy   <= 1'b1;
                    if (bit_done) begin
                        bit_idx <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    TX_OUT <= data_q[bit_idx];
                    Busy   <= 1'b1;
                    if (bit_done) begin
                        if (bit_idx == LAST_IDX) begin
                            state <= par_en_q ? PARITY : STOP;
                        end else begin
                            bit_idx <= bit_idx + IDX_ONE;
                        end
                    end
                end
                PARITY: begin
                    TX_OUT <= par_bit;
                    Busy   <= 1'b1;
                    if (bit_done) begin
                        state <= STOP;
                    end
                end
                STOP: begin
                    TX_OUT <= 1'b1;
                    Busy   <= 1'b1;
                    if (bit_done) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: queue-based line model checked every cycle,
// plus literal frame sequences for the directed cases.
module tb_uart_tx_frame;
    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [5:0] PRESCALE;
    logic       TX_OUT;
    logic       Busy;

    int n_cmp = 0;
    int n_bad = 0;

    uart_tx_frame #(.DATA_LENGTH(8), .PRESCALE_W(6)) dut (
        .CLK(CLK),
        .RST(RST),
        .P_DATA(P_DATA),
        .DATA_VALID(DATA_VALID),
        .PAR_EN(PAR_EN),
        .PAR_TYP(PAR_TYP),
        .PRESCALE(PRESCALE),
        .TX_OUT(TX_OUT),
        .Busy(Busy)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic tx;
        logic busy;
    } line_t;

    localparam line_t IDLE_LINE = '{tx: 1'b1, busy: 1'b0};

    line_t q[$];
    line_t cur;
    bit    live = 0;

    // The line value for every future cycle of an accepted frame.
    task automatic push_frame(input logic [7:0] d, input logic pe,
                              input logic pt, input logic [5:0] ps);
        int   p;
        logic bits[$];
        p = (ps == 0) ? 1 : int'(ps);
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (pe) bits.push_back(pt ? ~^d : ^d);
        bits.push_back(1'b1);
        foreach (bits[b])
            for (int c = 0; c < p; c++)
                q.push_back('{tx: bits[b], busy: 1'b1});
    endtask

    always @(posedge CLK) begin
        bit accept;
        if (RST) begin
            q.delete();
            cur  = IDLE_LINE;
            live = 1;
        end else if (live) begin
            accept = (q.size() == 0) && (DATA_VALID == 1'b1);
            cur = (q.size() != 0) ? q.pop_front() : IDLE_LINE;
            if (accept) push_frame(P_DATA, PAR_EN, PAR_TYP, PRESCALE);
        end
    end

    task automatic check(input string name, input logic gt, input logic gb,
                         input logic et, input logic eb);
        n_cmp++;
        if (gt !== et || gb !== eb) begin
            n_bad++;
            $display("FAIL %s @%0t: got tx=%b busy=%b, want tx=%b busy=%b",
                     name, $time, gt, gb, et, eb);
        end
    endtask

    always @(negedge CLK) begin
        if (live) check("model", TX_OUT, Busy, cur.tx, cur.busy);
    end

    // Entered at a negedge; sends one frame and checks it against literals.
    task automatic send_check(input string name, input logic [7:0] d,
                              input logic pe, input logic pt,
                              input logic [5:0] ps, input logic [15:0] bits,
                              input int n, input int p, input int pulse_at,
                              input bit toggle);
        P_DATA = d;
        PAR_EN = pe;
        PAR_TYP = pt;
        PRESCALE = ps;
        DATA_VALID = 1'b1;
        @(negedge CLK);
        check({name, "_pre"}, TX_OUT, Busy, 1'b1, 1'b0);
        DATA_VALID = 1'b0;
        for (int c = 0; c < n * p; c++) begin
            @(negedge CLK);
            check(name, TX_OUT, Busy, bits[n - 1 - c / p], 1'b1);
            DATA_VALID = (c == pulse_at);
            if (toggle) begin
                P_DATA = 8'($urandom);
                PAR_EN = ~PAR_EN;
                PAR_TYP = ~PAR_TYP;
                PRESCALE = 6'($urandom);
            end
        end
        DATA_VALID = 1'b0;
        @(negedge CLK);
        check({name, "_end"}, TX_OUT, Busy, 1'b1, 1'b0);
        @(negedge CLK);
        check({name, "_idle"}, TX_OUT, Busy, 1'b1, 1'b0);
    endtask

    initial begin
        logic [22:0] b2b_tx;
        logic [22:0] b2b_busy;
        RST = 1'b1;
        DATA_VALID = 1'b0;
        P_DATA = '0;
        PAR_EN = 1'b0;
        PAR_TYP = 1'b0;
        PRESCALE = 6'd1;
        @(negedge CLK);
        DATA_VALID = 1'b1;
        @(negedge CLK);
        check("reset", TX_OUT, Busy, 1'b1, 1'b0);
        RST = 1'b0;
        DATA_VALID = 1'b0;
        repeat (2) @(negedge CLK);
        check("rst_release_dv", TX_OUT, Busy, 1'b1, 1'b0);

        send_check("even_p1", 8'hA5, 1, 0, 6'd1, 16'b01010010101, 11, 1, -1, 0);
        send_check("odd_p4", 8'hA5, 1, 1, 6'd4, 16'b01010010111, 11, 4, -1, 0);
        send_check("nopar_p0", 8'h3C, 0, 0, 6'd0, 16'b0001111001, 10, 1, 5, 0);

        b2b_tx = 23'b00000000001_1_01111111101;
        b2b_busy = 23'b11111111111_0_11111111111;
        P_DATA = 8'h00;
        PAR_EN = 1'b1;
        PAR_TYP = 1'b0;
        PRESCALE = 6'd1;
        DATA_VALID = 1'b1;
        @(negedge CLK);
        check("b2b_pre", TX_OUT, Busy, 1'b1, 1'b0);
        for (int j = 0; j < 23; j++) begin
            @(negedge CLK);
            check("b2b", TX_OUT, Busy, b2b_tx[22 - j], b2b_busy[22 - j]);
            if (j == 0) P_DATA = 8'hFF;
            if (j == 11) DATA_VALID = 1'b0;
        end
        @(negedge CLK);
        check("b2b_end", TX_OUT, Busy, 1'b1, 1'b0);

        P_DATA = 8'h5A;
        PRESCALE = 6'd2;
        DATA_VALID = 1'b1;
        @(negedge CLK);
        DATA_VALID = 1'b0;
        repeat (9) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        check("rst_mid", TX_OUT, Busy, 1'b1, 1'b0);
        RST = 1'b0;
        @(negedge CLK);
        check("rst_mid_idle", TX_OUT, Busy, 1'b1, 1'b0);
        send_check("after_rst", 8'h96, 1, 1, 6'd2, 16'b00110100111, 11, 2, -1, 0);

        send_check("stable", 8'hC3, 1, 0, 6'd3, 16'b01100001101, 11, 3, -1, 1);

        for (int c = 0; c < 3000; c++) begin
            DATA_VALID = ($urandom_range(3) == 0);
            P_DATA = 8'($urandom);
            PAR_EN = 1'($urandom);
            PAR_TYP = 1'($urandom);
            PRESCALE = 6'($urandom_range(5));
            RST = ($urandom_range(399) == 0);
            @(negedge CLK);
        end
        RST = 1'b0;
        DATA_VALID = 1'b0;
        repeat (100) @(negedge CLK);
        check("final_idle", TX_OUT, Busy, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
